// File: rtl/gerencia_matriz_ram.sv
// Matrix manager: on inicia streams operands A and B out of RAM into flat buses; on grava writes the result matrix back.
// Load takes 2*N*N+1 cycles, store N*N; commands are accepted only while idle and are dropped while busy.
module gerencia_matriz_ram #(
  parameter int N      = 5,
  parameter int W      = 9,
  parameter int ADDR_W = 8,
  parameter int BASE_A = 0,
  parameter int BASE_B = 25,
  parameter int BASE_R = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inicia,
  input  logic              grava,
  input  logic [N*N*W-1:0]  matriz_resultante,
  output logic [N*N*W-1:0]  matriz1,
  output logic [N*N*W-1:0]  matriz2,
  output logic [ADDR_W-1:0] ram_endereco,
  output logic [W-1:0]      ram_dado_escrita,
  output logic              ram_grava,
  input  logic [W-1:0]      ram_dado_leitura,
  output logic              ocupado,
  output logic              concluido
);

  localparam int     NN    = N * N;
  localparam int     M     = 2 * NN;
  localparam int     CNT_W = $clog2(M + 2);
  localparam longint SPAN  = longint'(1) << ADDR_W;

  localparam logic [CNT_W-1:0]  CNT_UM   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DOIS = CNT_W'(2);
  localparam logic [CNT_W-1:0]  CNT_NN   = CNT_W'(NN);
  localparam logic [CNT_W-1:0]  CNT_M    = CNT_W'(M);
  localparam logic [CNT_W-1:0]  CNT_FIM  = CNT_W'(M + 1);
  localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(BASE_A);
  localparam logic [ADDR_W-1:0] END_B    = ADDR_W'(BASE_B);
  localparam logic [ADDR_W-1:0] END_R    = ADDR_W'(BASE_R);

  if (N < 1 || N > 8) begin : g_erro_n
    $fatal(1, "gerencia_matriz_ram: N must be within 1..8");
  end
  if (BASE_A + NN > SPAN || BASE_B + NN > SPAN || BASE_R + NN > SPAN) begin : g_erro_faixa
    $fatal(1, "gerencia_matriz_ram: a matrix region exceeds the RAM address space");
  end
  if (!((BASE_A + NN <= BASE_B) || (BASE_B + NN <= BASE_A)) ||
      !((BASE_A + NN <= BASE_R) || (BASE_R + NN <= BASE_A)) ||
      !((BASE_B + NN <= BASE_R) || (BASE_R + NN <= BASE_B))) begin : g_erro_sobreposicao
    $fatal(1, "gerencia_matriz_ram: matrix regions A, B and R overlap");
  end

  typedef enum logic [1:0] {OCIOSO, LER, ESCREVE, FIM} estado_t;

  estado_t            estado_q, estado_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [M*W-1:0]     shadow_q, shadow_d;
  logic [NN*W-1:0]    snap_q, snap_d;
  logic [NN*W-1:0]    matriz1_q, matriz1_d;
  logic [NN*W-1:0]    matriz2_q, matriz2_d;
  logic [ADDR_W-1:0]  endereco_q, endereco_d;
  logic [W-1:0]       dado_q, dado_d;
  logic               grava_q, grava_d;
  logic               ocupado_q, ocupado_d;
  logic               concluido_q, concluido_d;

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    snap_d      = snap_q;
    matriz1_d   = matriz1_q;
    matriz2_d   = matriz2_q;
    endereco_d  = endereco_q;
    dado_d      = dado_q;
    grava_d     = 1'b0;
    ocupado_d   = ocupado_q;
    concluido_d = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (inicia) begin
          estado_d   = LER;
          ocupado_d  = 1'b1;
          cnt_d      = CNT_UM;
          endereco_d = END_A;
        end else if (grava) begin
          estado_d   = ESCREVE;
          ocupado_d  = 1'b1;
          cnt_d      = CNT_UM;
          snap_d     = matriz_resultante;
          grava_d    = 1'b1;
          endereco_d = END_R;
          dado_d     = matriz_resultante[W-1:0];
        end
      end

      // cnt_q is the index of the edge being evaluated: issue address k, capture data of k-2.
      LER: begin
        if (cnt_q < CNT_NN)
          endereco_d = END_A + ADDR_W'(cnt_q);
        else if (cnt_q < CNT_M)
          endereco_d = END_B + ADDR_W'(cnt_q - CNT_NN);

        if (cnt_q >= CNT_DOIS)
          shadow_d[(int'(cnt_q) - 2) * W +: W] = ram_dado_leitura;

        if (cnt_q == CNT_FIM) begin
          matriz1_d   = shadow_d[NN*W-1:0];
          matriz2_d   = shadow_d[M*W-1:NN*W];
          estado_d    = FIM;
          ocupado_d   = 1'b0;
          concluido_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end

      ESCREVE: begin
        if (cnt_q == CNT_NN) begin
          estado_d    = FIM;
          ocupado_d   = 1'b0;
          concluido_d = 1'b1;
        end else begin
          grava_d    = 1'b1;
          endereco_d = END_R + ADDR_W'(cnt_q);
          dado_d     = snap_q[int'(cnt_q) * W +: W];
          cnt_d      = cnt_q + CNT_UM;
        end
      end

      FIM: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d  = OCIOSO;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      cnt_q       <= '0;
      shadow_q    <= '0;
      snap_q      <= '0;
      matriz1_q   <= '0;
      matriz2_q   <= '0;
      endereco_q  <= '0;
      dado_q      <= '0;
      grava_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      snap_q      <= snap_d;
      matriz1_q   <= matriz1_d;
      matriz2_q   <= matriz2_d;
      endereco_q  <= endereco_d;
      dado_q      <= dado_d;
      grava_q     <= grava_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
    end
  end

  assign matriz1          = matriz1_q;
  assign matriz2          = matriz2_q;
  assign ram_endereco     = endereco_q;
  assign ram_dado_escrita = dado_q;
  assign ram_grava        = grava_q;
  assign ocupado          = ocupado_q;
  assign concluido        = concluido_q;

endmodule

// File: tb/tb_gerencia_matriz_ram.sv
// Bench for gerencia_matriz_ram: default 5x5 instance plus a 2x2/16-bit instance, each with its own RAM model.
module tb_gerencia_matriz_ram;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  // Default instance signals
  logic         inicia = 1'b0, grava = 1'b0;
  logic [224:0] mres = '0, matriz1, matriz2;
  logic [7:0]   ram_endereco;
  logic [8:0]   ram_dado_escrita, ram_dado_leitura;
  logic         ram_grava, ocupado, concluido;
  logic [8:0]   mem [256];

  // Variant instance signals
  logic         inicia_p = 1'b0, grava_p = 1'b0;
  logic [63:0]  mres_p = '0, matriz1_p, matriz2_p;
  logic [7:0]   ram_endereco_p;
  logic [15:0]  ram_dado_escrita_p, ram_dado_leitura_p;
  logic         ram_grava_p, ocupado_p, concluido_p;
  logic [15:0]  mem2 [256];

  logic [63:0] ld_q[$], wr_q[$], ld2_q[$], wr2_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  gerencia_matriz_ram u_dut (
    .clk(clk), .rst_n(rst_n), .inicia(inicia), .grava(grava),
    .matriz_resultante(mres), .matriz1(matriz1), .matriz2(matriz2),
    .ram_endereco(ram_endereco), .ram_dado_escrita(ram_dado_escrita),
    .ram_grava(ram_grava), .ram_dado_leitura(ram_dado_leitura),
    .ocupado(ocupado), .concluido(concluido)
  );

  gerencia_matriz_ram #(
    .N(2), .W(16), .ADDR_W(8), .BASE_A(16), .BASE_B(32), .BASE_R(48)
  ) u_dut_p (
    .clk(clk), .rst_n(rst_n), .inicia(inicia_p), .grava(grava_p),
    .matriz_resultante(mres_p), .matriz1(matriz1_p), .matriz2(matriz2_p),
    .ram_endereco(ram_endereco_p), .ram_dado_escrita(ram_dado_escrita_p),
    .ram_grava(ram_grava_p), .ram_dado_leitura(ram_dado_leitura_p),
    .ocupado(ocupado_p), .concluido(concluido_p)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) begin
        mem[a]  <= 9'(a + 1);
        mem2[a] <= 16'hA000 + 16'(a);
      end
    end else begin
      if (ram_grava)   mem[ram_endereco]    <= ram_dado_escrita;
      if (ram_grava_p) mem2[ram_endereco_p] <= ram_dado_escrita_p;
    end
    ram_dado_leitura   <= mem[ram_endereco];
    ram_dado_leitura_p <= mem2[ram_endereco_p];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  // Every write cycle must match the next queued expectation; an empty queue yields an impossible value.
  always @(negedge clk) begin
    logic [63:0] e;
    if (ram_grava) begin
      e = (wr_q.size() != 0) ? wr_q.pop_front() : '1;
      chk("wr", 64'({ram_endereco, ram_dado_escrita}), e);
    end
    if (ram_grava_p) begin
      e = (wr2_q.size() != 0) ? wr2_q.pop_front() : '1;
      chk("wr_p", 64'({ram_endereco_p, ram_dado_escrita_p}), e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic op_d(input logic ini, input logic grv, input int busy_at,
                      input int exp_cyc, input string tag);
    int cyc, moved, wr_in_load;
    logic [224:0] prev1;
    if (ini) begin
      for (int i = 0; i < 25; i++) ld_q.push_back(64'(i + 1));
      for (int i = 0; i < 25; i++) ld_q.push_back(64'(26 + i));
    end else if (grv) begin
      for (int i = 0; i < 25; i++) wr_q.push_back(64'({8'(50 + i), mres[i*9 +: 9]}));
    end
    prev1  = matriz1;
    inicia = ini;
    grava  = grv;
    @(posedge clk); #1;
    inicia = 1'b0;
    grava  = 1'b0;
    mres   = '1;
    chk({tag, "_ocupado"}, 64'(ocupado), 64'(1));
    cyc = 0; moved = 0; wr_in_load = 0;
    while (cyc < 200) begin
      grava = (cyc == busy_at);
      @(posedge clk); #1;
      grava = 1'b0;
      cyc++;
      if (concluido) break;
      if (matriz1 != prev1) moved++;
      if (ram_grava && ini) wr_in_load++;
    end
    chk({tag, "_latencia"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_ocupado_fim"}, 64'(ocupado), 64'(0));
    chk({tag, "_matriz1_estavel"}, 64'(moved), 64'(0));
    if (ini) begin
      chk({tag, "_sem_escrita"}, 64'(wr_in_load), 64'(0));
      for (int i = 0; i < 25; i++)
        chk($sformatf("%s_m1_%0d", tag, i), 64'(matriz1[i*9 +: 9]), ld_q.pop_front());
      for (int i = 0; i < 25; i++)
        chk($sformatf("%s_m2_%0d", tag, i), 64'(matriz2[i*9 +: 9]), ld_q.pop_front());
    end
    @(posedge clk); #1;
    chk({tag, "_pulso"}, 64'(concluido), 64'(0));
    chk({tag, "_fila_wr"}, 64'(wr_q.size()), 64'(0));
  endtask

  task automatic op_p(input logic ini, input logic grv, input int exp_cyc, input string tag);
    int cyc;
    if (ini) begin
      for (int i = 0; i < 4; i++) ld2_q.push_back(64'(16'hA010 + 16'(i)));
      for (int i = 0; i < 4; i++) ld2_q.push_back(64'(16'hA020 + 16'(i)));
    end else if (grv) begin
      for (int i = 0; i < 4; i++) wr2_q.push_back(64'({8'(48 + i), mres_p[i*16 +: 16]}));
    end
    inicia_p = ini;
    grava_p  = grv;
    @(posedge clk); #1;
    inicia_p = 1'b0;
    grava_p  = 1'b0;
    cyc = 0;
    while (cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (concluido_p) break;
    end
    chk({tag, "_latencia"}, 64'(cyc), 64'(exp_cyc));
    if (ini) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_m1_%0d", tag, i), 64'(matriz1_p[i*16 +: 16]), ld2_q.pop_front());
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_m2_%0d", tag, i), 64'(matriz2_p[i*16 +: 16]), ld2_q.pop_front());
    end
    @(posedge clk); #1;
    chk({tag, "_fila_wr"}, 64'(wr2_q.size()), 64'(0));
  endtask

  task automatic chk_mem_r(input string tag, input int n_new, input int new_base);
    int bad = 0;
    for (int a = 0; a < 25; a++) begin
      if (mem[50 + a] != 9'((a < n_new) ? new_base + a : 100 + a)) bad++;
    end
    chk(tag, 64'(bad), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m1"}, 64'(matriz1 != '0), 64'(0));
    chk({tag, "_m2"}, 64'(matriz2 != '0), 64'(0));
    chk({tag, "_end"}, 64'(ram_endereco), 64'(0));
    chk({tag, "_dado"}, 64'(ram_dado_escrita), 64'(0));
    chk({tag, "_grava"}, 64'(ram_grava), 64'(0));
    chk({tag, "_ocupado"}, 64'(ocupado), 64'(0));
    chk({tag, "_concluido"}, 64'(concluido), 64'(0));
  endtask

  initial begin
    int busy_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;

    op_d(1'b1, 1'b0, -1, 51, "ld");

    for (int i = 0; i < 25; i++) mres[i*9 +: 9] = 9'(100 + i);
    op_d(1'b0, 1'b1, -1, 25, "st");
    chk_mem_r("st_mem", 0, 0);

    op_d(1'b1, 1'b1, -1, 51, "both");
    busy_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ocupado) busy_cnt++;
    end
    chk("both_sem_replay", 64'(busy_cnt), 64'(0));

    op_d(1'b1, 1'b0, 10, 51, "busy");
    chk_mem_r("busy_mem_r", 0, 0);

    // Store aborted by reset while write j=7 is on the bus
    for (int i = 0; i < 25; i++) mres[i*9 +: 9] = 9'(200 + i);
    for (int j = 0; j < 7; j++) wr_q.push_back(64'({8'(50 + j), 9'(200 + j)}));
    grava = 1'b1;
    @(posedge clk); #1;
    grava = 1'b0;
    mres  = '1;
    repeat (7) @(posedge clk);
    #1;
    chk("rst_wr7_grava", 64'(ram_grava), 64'(1));
    chk("rst_wr7_end", 64'(ram_endereco), 64'(57));
    #1 rst_n = 1'b0;
    #1;
    chk_zero("rst_meio");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_fila_wr", 64'(wr_q.size()), 64'(0));
    chk_mem_r("rst_mem_r", 7, 200);

    op_d(1'b1, 1'b0, -1, 51, "rld");

    op_p(1'b1, 1'b0, 9, "p_ld");
    for (int i = 0; i < 4; i++) mres_p[i*16 +: 16] = 16'h5000 + 16'(i);
    op_p(1'b0, 1'b1, 4, "p_st");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
